// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU instruction RAM: length, N 4-byte words, XOR checksum.
// Holds the CPU core in reset until a complete frame has been written and verified.
module program_loader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28,
    parameter int DEPTH       = 256
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iStart,
    input  logic [7:0]             iRxData,
    input  logic                   iRxValid,
    output logic                   oRxReady,
    output logic                   oWriteEnable,
    output logic [ADDR_WIDTH-1:0]  oWriteAddress,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oCpuReset,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oError
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int TOP_W = INSTR_WIDTH - 24;
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_B3,
        S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            len_q, len_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [7:0]             chk_q, chk_d;
    logic                   fmt_q, fmt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic             byte_fire;
    logic [15:0]      n_rx;
    logic [CNT_W-1:0] count_inc;

    always_comb begin
        oRxReady = 1'b0;
        case (state_q)
            S_LEN_LO, S_LEN_HI, S_B0, S_B1, S_B2, S_B3, S_CHECK: oRxReady = 1'b1;
            default: oRxReady = 1'b0;
        endcase
    end

    assign byte_fire = iRxValid && oRxReady;
    assign n_rx      = {iRxData, len_q[7:0]};
    assign count_inc = count_q + CNT_W'(1);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        chk_d   = chk_q;
        fmt_d   = fmt_q;
        instr_d = instr_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (iStart) begin
                    state_d = S_LEN_LO;
                    count_d = '0;
                    chk_d   = '0;
                    fmt_d   = 1'b0;
                end
            end
            S_LEN_LO: begin
                if (byte_fire) begin
                    len_d[7:0] = iRxData;
                    chk_d      = chk_q ^ iRxData;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (byte_fire) begin
                    len_d[15:8] = iRxData;
                    chk_d       = chk_q ^ iRxData;
                    if ({1'b0, n_rx} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else if (n_rx == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (byte_fire) begin
                    instr_d[7:0] = iRxData;
                    chk_d        = chk_q ^ iRxData;
                    state_d      = S_B1;
                end
            end
            S_B1: begin
                if (byte_fire) begin
                    instr_d[15:8] = iRxData;
                    chk_d         = chk_q ^ iRxData;
                    state_d       = S_B2;
                end
            end
            S_B2: begin
                if (byte_fire) begin
                    instr_d[23:16] = iRxData;
                    chk_d          = chk_q ^ iRxData;
                    state_d        = S_B3;
                end
            end
            S_B3: begin
                if (byte_fire) begin
                    instr_d[INSTR_WIDTH-1:24] = iRxData[TOP_W-1:0];
                    chk_d                     = chk_q ^ iRxData;
                    // Bits above the instruction width must be zero; remember any violation.
                    if (iRxData[7:TOP_W] != '0) fmt_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                count_d = count_inc;
                state_d = (count_inc == CNT_W'(len_q)) ? S_CHECK : S_B0;
            end
            S_CHECK: begin
                if (byte_fire) begin
                    state_d = (iRxData == chk_q && !fmt_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address register follows the counter, so it only moves after the WRITE cycle.
        addr_d = count_d[ADDR_WIDTH-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            count_q <= '0;
            chk_q   <= '0;
            fmt_q   <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            chk_q   <= chk_d;
            fmt_q   <= fmt_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
        end
    end

    assign oWriteEnable  = (state_q == S_WRITE);
    assign oWriteAddress = addr_q;
    assign oInstruction  = instr_q;
    assign oDone         = (state_q == S_DONE);
    assign oError        = (state_q == S_ERR);
    assign oCpuReset     = (state_q != S_DONE);
    assign oBusy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a frame-level model predicts writes and final status,
// a monitor compares every RAM write strobe against the expected-write queue.
module tb_program_loader;

    localparam int DEPTH = 256;

    typedef struct {
        logic [15:0] addr;
        logic [27:0] data;
    } wr_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iStart = 1'b0;
    logic [7:0]  iRxData = 8'h00;
    logic        iRxValid = 1'b0;
    logic        oRxReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oInstruction;
    logic        oCpuReset;
    logic        oBusy;
    logic        oDone;
    logic        oError;

    int n_checks = 0;
    int n_pass   = 0;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] frame_q[$];

    program_loader #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .DEPTH(DEPTH)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iRxData      (iRxData),
        .iRxValid     (iRxValid),
        .oRxReady     (oRxReady),
        .oWriteEnable (oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oInstruction (oInstruction),
        .oCpuReset    (oCpuReset),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oError       (oError)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge Clock) begin
        if (Reset && oWriteEnable) begin
            check("ready_during_write", 32'(oRxReady), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(oWriteAddress), 32'(mon_e.addr));
                check("write_data", 32'(oInstruction), 32'(mon_e.data));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, 32'(oRxReady), 32'd0);
        check({tag, "_we"},       32'(oWriteEnable), 32'd0);
        check({tag, "_addr"},     32'(oWriteAddress), 32'd0);
        check({tag, "_instr"},    32'(oInstruction), 32'd0);
        check({tag, "_cpu_rst"},  32'(oCpuReset), 32'd1);
        check({tag, "_busy"},     32'(oBusy), 32'd0);
        check({tag, "_done"},     32'(oDone), 32'd0);
        check({tag, "_error"},    32'(oError), 32'd0);
    endtask

    task automatic pulse_start();
        iStart = 1'b1;
        @(posedge Clock); #1;
        iStart = 1'b0;
    endtask

    // Offers one byte with random valid gaps until it is accepted or the budget runs out.
    task automatic send_byte(input logic [7:0] b, input int vprob, output bit ok);
        int cyc = 0;
        bit hs = 1'b0;
        ok = 1'b1;
        while (!hs) begin
            iRxValid = ($urandom_range(0, 99) < vprob);
            iRxData  = iRxValid ? b : 8'($urandom);
            @(negedge Clock);
            hs = iRxValid && oRxReady;
            @(posedge Clock); #1;
            cyc++;
            if (!hs && cyc > 500) begin
                check("byte_timeout", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
        iRxValid = 1'b0;
        iRxData  = 8'($urandom);
    endtask

    task automatic build_frame(input int n, input int bad_idx, input logic [7:0] chk_flip);
        logic [7:0] x;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                frame_q.push_back(8'($urandom));
                frame_q.push_back(8'($urandom));
                frame_q.push_back(8'($urandom));
                if (i == bad_idx) frame_q.push_back({4'($urandom_range(1, 15)), 4'($urandom)});
                else              frame_q.push_back({4'h0, 4'($urandom)});
            end
            x = 8'h00;
            foreach (frame_q[k]) x ^= frame_q[k];
            frame_q.push_back(x ^ chk_flip);
        end
    endtask

    // Predicts the outcome of frame_q from the frame rules, then drives it and checks the result.
    task automatic run_frame(input string tag, input int vprob, input bit poke_start);
        int n, consume;
        bit reject, fmt_bad, exp_ok, ok;
        logic [7:0] x;
        wr_t w;

        n       = int'(frame_q[0]) | (int'(frame_q[1]) << 8);
        reject  = (n > DEPTH);
        consume = reject ? 2 : (2 + 4 * n + 1);
        fmt_bad = 1'b0;
        if (!reject) begin
            for (int i = 0; i < n; i++) begin
                w.addr = 16'(i);
                w.data = {frame_q[2 + 4*i + 3][3:0], frame_q[2 + 4*i + 2],
                          frame_q[2 + 4*i + 1], frame_q[2 + 4*i]};
                exp_q.push_back(w);
                if (frame_q[2 + 4*i + 3][7:4] != 4'h0) fmt_bad = 1'b1;
            end
        end
        x = 8'h00;
        for (int i = 0; i < consume - 1; i++) x ^= frame_q[i];
        exp_ok = !reject && !fmt_bad && (x == frame_q[consume - 1]);

        pulse_start();
        for (int i = 0; i < consume; i++) begin
            send_byte(frame_q[i], vprob, ok);
            if (!ok) break;
            if (i == 1 && poke_start && !reject) pulse_start();
        end

        if (reject) begin
            iRxValid = 1'b1;
            iRxData  = 8'($urandom);
            @(negedge Clock);
            check({tag, "_reject_ready"}, 32'(oRxReady), 32'd0);
            @(posedge Clock); #1;
            iRxValid = 1'b0;
        end

        @(negedge Clock);
        check({tag, "_done"},    32'(oDone), 32'(exp_ok));
        check({tag, "_error"},   32'(oError), 32'(!exp_ok));
        check({tag, "_cpu_rst"}, 32'(oCpuReset), 32'(!exp_ok));
        check({tag, "_busy"},    32'(oBusy), 32'd0);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge Clock); #1;
    endtask

    task automatic load_t1();
        frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h02, 8'h19};
    endtask

    initial begin
        bit ok;
        int n;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_reset_outputs("por");
        @(posedge Clock); #1;
        Reset = 1'b1;
        @(posedge Clock); #1;

        load_t1();
        run_frame("t1", 100, 1'b0);
        frame_q = {8'h00, 8'h00, 8'h00};
        run_frame("t2", 100, 1'b0);
        frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h02, 8'h18};
        run_frame("t3", 100, 1'b0);
        frame_q = {8'h01, 8'h01};
        run_frame("t4", 100, 1'b0);
        frame_q = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        run_frame("t5", 100, 1'b0);
        load_t1();
        run_frame("t6_stall", 40, 1'b1);

        // Abandon a load after three bytes, then confirm a clean reload.
        load_t1();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(frame_q[i], 60, ok);
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_outputs("midrst");
        @(posedge Clock); #1;
        Reset = 1'b1;
        exp_q.delete();
        @(posedge Clock); #1;
        load_t1();
        run_frame("t6_reload", 70, 1'b0);

        build_frame(DEPTH, -1, 8'h00);
        run_frame("n_depth", 80, 1'b1);
        build_frame(DEPTH + 1, -1, 8'h00);
        run_frame("n_depth_p1", 80, 1'b0);
        build_frame(16'hFFFF, -1, 8'h00);
        run_frame("n_max", 80, 1'b0);

        for (int r = 0; r < 24; r++) begin
            n = $urandom_range(0, 6);
            case ($urandom_range(0, 5))
                0:       build_frame(n, $urandom_range(0, 6), 8'h00);
                1:       build_frame(n, -1, 8'(1 << $urandom_range(0, 7)));
                2:       build_frame($urandom_range(DEPTH + 1, 16'hFFFF), -1, 8'h00);
                default: build_frame(n, -1, 8'h00);
            endcase
            run_frame("rand", $urandom_range(30, 100), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
